// File: rtl/row_request_scheduler_pkg.sv
// Shared definitions for the row request scheduler and its stream consumer.
// Contents: scheduler state encoding, default row size, and a helper the
// consumer uses to derive its beats-per-row count from the same row size.
package row_request_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } sched_state_t;

  // One request covers one row; the consumer's per-row beat count comes from this too.
  localparam int ROW_BYTES_DEFAULT = 2048;

  function automatic int data_cycles_per_row(input int bytes_per_beat);
    return ROW_BYTES_DEFAULT / bytes_per_beat;
  endfunction

endpackage

// File: rtl/row_request_scheduler_if.sv
// Row read-request stream between the scheduler and the PCIe/QSFP request path.
// Signals: AXIS_RQ_TDATA (row byte address), AXIS_RQ_TVALID, AXIS_RQ_TREADY.
// master = scheduler side, slave = downstream request consumer.
interface row_request_scheduler_if #(
  parameter int ADDR_WIDTH = 64
);
  logic [ADDR_WIDTH-1:0] AXIS_RQ_TDATA;
  logic                  AXIS_RQ_TVALID;
  logic                  AXIS_RQ_TREADY;

  modport master (
    output AXIS_RQ_TDATA,
    output AXIS_RQ_TVALID,
    input  AXIS_RQ_TREADY
  );

  modport slave (
    input  AXIS_RQ_TDATA,
    input  AXIS_RQ_TVALID,
    output AXIS_RQ_TREADY
  );
endinterface

// File: rtl/row_request_scheduler_credit_counter.sv
// Credit window tracker: counts requested-but-incomplete rows and stray completions.
// Ports: clk/reset, clear (new job), inc (request handshake), dec (row complete);
// outputs outstanding, has_credit (room in window), spurious (saturating count).
module row_request_scheduler_credit_counter #(
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        inc,
  input  logic        dec,
  output logic [7:0]  outstanding,
  output logic        has_credit,
  output logic [15:0] spurious
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      outstanding <= '0;
      spurious    <= '0;
    end else if (inc && !dec) begin
      outstanding <= outstanding + 8'd1;
    end else if (dec && !inc) begin
      // A completion with nothing in flight is an upstream fault: count it, keep credits at 0.
      if (outstanding == 8'd0) begin
        if (spurious != 16'hFFFF) spurious <= spurious + 16'd1;
      end else begin
        outstanding <= outstanding - 8'd1;
      end
    end
  end

  // Registered count only, so a request is never issued into a full window.
  assign has_credit = (outstanding < 8'(MAX_OUTSTANDING));

endmodule

// File: rtl/row_request_scheduler.sv
// Issues one read request per row of a job, throttled by a window of outstanding rows.
// Ports: start/abort/base_addr/total_rows from control regs; rq = request stream;
// row_complete returns credits; idle/outstanding/rows_requested/spurious/job_done are status.
module row_request_scheduler
  import row_request_scheduler_pkg::*;
#(
  parameter int ADDR_WIDTH      = 64,
  parameter int ROW_BYTES       = ROW_BYTES_DEFAULT,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [31:0]           total_rows,
  input  logic                  row_complete,
  row_request_scheduler_if.master rq,
  output logic                  row_requestor_idle,
  output logic [7:0]            outstanding,
  output logic [31:0]           rows_requested,
  output logic [15:0]           spurious_completions,
  output logic                  job_done
);

  localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(ROW_BYTES);

  sched_state_t          state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           total_q;
  logic                  tvalid;
  logic                  abort_seen;
  logic                  has_credit;
  logic                  handshake;
  logic                  clear_credits;
  logic [31:0]           rows_next;

  assign handshake     = tvalid && rq.AXIS_RQ_TREADY;
  assign clear_credits = (state == IDLE) && start;
  assign rows_next     = rows_requested + 32'd1;

  assign rq.AXIS_RQ_TDATA  = addr;
  assign rq.AXIS_RQ_TVALID = tvalid;

  row_request_scheduler_credit_counter #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_credit (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear_credits),
    .inc        (handshake),
    .dec        (row_complete),
    .outstanding(outstanding),
    .has_credit (has_credit),
    .spurious   (spurious_completions)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= IDLE;
      tvalid             <= 1'b0;
      addr               <= '0;
      total_q            <= '0;
      rows_requested     <= '0;
      abort_seen         <= 1'b0;
      row_requestor_idle <= 1'b1;
      job_done           <= 1'b0;
    end else begin
      job_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            addr           <= base_addr;
            total_q        <= total_rows;
            rows_requested <= '0;
            abort_seen     <= 1'b0;
            if (total_rows == 32'd0) begin
              state <= DRAIN;
            end else begin
              state              <= ISSUE;
              row_requestor_idle <= 1'b0;
            end
          end
        end
        ISSUE: begin
          if (handshake) begin
            rows_requested <= rows_next;
            addr           <= addr + ROW_STEP;
            // Drop valid for a cycle so the credit check sees the updated count.
            tvalid         <= 1'b0;
            if (rows_next == total_q || abort_seen || abort) begin
              state              <= DRAIN;
              row_requestor_idle <= 1'b1;
            end
          end else if (tvalid) begin
            // A presented request must complete; remember the abort for afterwards.
            if (abort) abort_seen <= 1'b1;
          end else if (abort) begin
            state              <= DRAIN;
            row_requestor_idle <= 1'b1;
          end else begin
            tvalid <= has_credit;
          end
        end
        DRAIN: begin
          if (outstanding == 8'd0) begin
            job_done <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_row_request_scheduler.sv
module tb_row_request_scheduler;
  import row_request_scheduler_pkg::*;

  localparam int          AW   = 64;
  localparam int          MAXO = 16;
  localparam logic [63:0] RB   = 64'(ROW_BYTES_DEFAULT);

  logic        clk = 1'b0;
  logic        reset, start, abort, row_complete;
  logic [63:0] base_addr;
  logic [31:0] total_rows;
  logic        row_requestor_idle, job_done;
  logic [7:0]  outstanding;
  logic [31:0] rows_requested;
  logic [15:0] spurious_completions;

  row_request_scheduler_if #(.ADDR_WIDTH(AW)) rq ();

  row_request_scheduler #(
    .ADDR_WIDTH(AW), .ROW_BYTES(ROW_BYTES_DEFAULT), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .base_addr(base_addr), .total_rows(total_rows), .row_complete(row_complete),
    .rq(rq), .row_requestor_idle(row_requestor_idle), .outstanding(outstanding),
    .rows_requested(rows_requested), .spurious_completions(spurious_completions),
    .job_done(job_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Transaction-level reference: job parameters, handshake count, credit count.
  int          m_out, m_spur, done_pulses;
  int unsigned m_hs, m_total;
  logic [63:0] m_base;
  bit          m_busy, m_abort;
  logic [63:0] hs_log[$];
  logic [63:0] exp_a[4] = '{64'h1000, 64'h1800, 64'h2000, 64'h2800};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic hs, rc, pend;
    logic [63:0] pend_dat;
    hs       = rq.AXIS_RQ_TVALID && rq.AXIS_RQ_TREADY;
    rc       = row_complete;
    pend     = rq.AXIS_RQ_TVALID && !rq.AXIS_RQ_TREADY;
    pend_dat = rq.AXIS_RQ_TDATA;
    if (rq.AXIS_RQ_TVALID === 1'b1) begin
      chk("tdata", rq.AXIS_RQ_TDATA, m_base + 64'(m_hs) * RB);
      chk("tvalid_in_window", 64'(m_busy && m_hs < m_total && m_out < MAXO), 64'd1);
    end
    if (hs === 1'b1) hs_log.push_back(rq.AXIS_RQ_TDATA);
    @(posedge clk); #1;
    if (reset) begin
      m_out = 0; m_hs = 0; m_spur = 0; m_busy = 0; m_abort = 0;
    end else if (start && !m_busy) begin
      m_out = 0; m_hs = 0; m_spur = 0; m_busy = 1; m_abort = 0;
      m_base = base_addr; m_total = total_rows;
    end else begin
      if (abort && m_busy) m_abort = 1;
      if (hs === 1'b1) m_hs++;
      if (hs === 1'b1 && !rc) m_out++;
      else if (rc && hs !== 1'b1) begin
        if (m_out == 0) begin
          if (m_spur < 65535) m_spur++;
        end else m_out--;
      end
    end
    if (!reset && pend === 1'b1) begin
      chk("tvalid_hold", 64'(rq.AXIS_RQ_TVALID), 64'd1);
      chk("tdata_hold", rq.AXIS_RQ_TDATA, pend_dat);
    end
    chk("outstanding", 64'(outstanding), 64'(m_out));
    chk("rows_requested", 64'(rows_requested), 64'(m_hs));
    chk("spurious", 64'(spurious_completions), 64'(m_spur));
    if (!m_abort) chk("idle", 64'(row_requestor_idle), 64'(!(m_busy && m_hs < m_total)));
    if (job_done === 1'b1) begin
      done_pulses++;
      chk("done_while_busy", 64'(m_busy), 64'd1);
      chk("done_credits", 64'(m_out), 64'd0);
      if (!m_abort) chk("done_rows", 64'(m_hs), 64'(m_total));
      m_busy = 0;
    end
  endtask

  task automatic start_job(input logic [63:0] b, input logic [31:0] n);
    base_addr = b; total_rows = n; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic finish_job(input int budget);
    int k;
    k = 0;
    rq.AXIS_RQ_TREADY = 1'b1;
    while (m_busy && k < budget) begin
      row_complete = (m_out > 0);
      step();
      k++;
    end
    row_complete = 1'b0;
    chk("job_finished", 64'(m_busy), 64'd0);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_tvalid"}, 64'(rq.AXIS_RQ_TVALID), 64'd0);
    chk({tag, "_tdata"}, rq.AXIS_RQ_TDATA, 64'd0);
    chk({tag, "_idle"}, 64'(row_requestor_idle), 64'd1);
    chk({tag, "_outstanding"}, 64'(outstanding), 64'd0);
    chk({tag, "_rows"}, 64'(rows_requested), 64'd0);
    chk({tag, "_spurious"}, 64'(spurious_completions), 64'd0);
    chk({tag, "_job_done"}, 64'(job_done), 64'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic [63:0] held, b;
    logic [31:0] n;
    m_out = 0; m_spur = 0; m_hs = 0; m_total = 0; m_base = '0; m_busy = 0; m_abort = 0;
    done_pulses = 0;
    reset = 1'b1; start = 1'b0; abort = 1'b0; row_complete = 1'b0;
    base_addr = '0; total_rows = '0; rq.AXIS_RQ_TREADY = 1'b0;
    step(); step();
    chk_reset_values("rst");
    reset = 1'b0;
    step();

    // A: four rows, immediate completions
    hs_log.delete(); done_pulses = 0;
    rq.AXIS_RQ_TREADY = 1'b1;
    start_job(64'h1000, 32'd4);
    chk("a_idle_low", 64'(row_requestor_idle), 64'd0);
    finish_job(100);
    chk("a_count", 64'(hs_log.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      chk("a_addr", (hs_log.size() > i) ? hs_log[i] : '1, exp_a[i]);
    chk("a_done_pulses", 64'(done_pulses), 64'd1);

    // B: credit window stall, then one credit releases exactly one request
    start_job(64'h0010_0000, 32'd40);
    repeat (60) step();
    chk("b_rows16", 64'(rows_requested), 64'd16);
    chk("b_out16", 64'(outstanding), 64'd16);
    chk("b_stall", 64'(rq.AXIS_RQ_TVALID), 64'd0);
    row_complete = 1'b1; step(); row_complete = 1'b0;
    repeat (20) step();
    chk("b_one_more", 64'(rows_requested), 64'd17);
    chk("b_out_after", 64'(outstanding), 64'd16);
    abort = 1'b1; step(); abort = 1'b0;
    chk("b_abort_idle", 64'(row_requestor_idle), 64'd1);
    finish_job(200);
    chk("b_rows_final", 64'(rows_requested), 64'd17);

    // C: abort while a request is held off by TREADY
    rq.AXIS_RQ_TREADY = 1'b0;
    start_job(64'hABCD_0000, 32'd8);
    step();
    chk("c_tvalid_up", 64'(rq.AXIS_RQ_TVALID), 64'd1);
    held = 64'hABCD_0000;
    for (int i = 0; i < 10; i++) begin
      abort = (i == 3);
      step();
      chk("c_tdata_stable", rq.AXIS_RQ_TDATA, held);
    end
    abort = 1'b0; rq.AXIS_RQ_TREADY = 1'b1;
    step();
    chk("c_rows1", 64'(rows_requested), 64'd1);
    chk("c_drain_idle", 64'(row_requestor_idle), 64'd1);
    chk("c_tvalid_low", 64'(rq.AXIS_RQ_TVALID), 64'd0);
    done_pulses = 0;
    finish_job(50);
    chk("c_done", 64'(done_pulses), 64'd1);
    chk("c_rows_final", 64'(rows_requested), 64'd1);

    // D: simultaneous handshake and completion, then a stray completion
    start_job(64'h0, 32'd20);
    k = 0;
    while (!(m_out == 5 && rq.AXIS_RQ_TVALID) && k < 50) begin step(); k++; end
    chk("d_reach5", 64'(m_out == 5 && rq.AXIS_RQ_TVALID), 64'd1);
    row_complete = 1'b1; step(); row_complete = 1'b0;
    chk("d_same_cycle", 64'(outstanding), 64'd5);
    chk("d_rows6", 64'(rows_requested), 64'd6);
    abort = 1'b1; step(); abort = 1'b0;
    finish_job(100);
    row_complete = 1'b1; step(); row_complete = 1'b0;
    chk("d_spurious", 64'(spurious_completions), 64'd1);
    chk("d_out0", 64'(outstanding), 64'd0);

    // E: empty job timing, then start during ISSUE is ignored
    start_job(64'h5000, 32'd0);
    chk("e_c1_done", 64'(job_done), 64'd0);
    chk("e_c1_idle", 64'(row_requestor_idle), 64'd1);
    step();
    chk("e_c2_done", 64'(job_done), 64'd1);
    chk("e_c2_tvalid", 64'(rq.AXIS_RQ_TVALID), 64'd0);
    step();
    chk("e_c3_done", 64'(job_done), 64'd0);
    hs_log.delete();
    rq.AXIS_RQ_TREADY = 1'b0;
    start_job(64'h2_0000, 32'd3);
    step();
    base_addr = 64'h9_0000; total_rows = 32'd100; start = 1'b1; step(); start = 1'b0;
    finish_job(100);
    chk("e_ignored_rows", 64'(rows_requested), 64'd3);
    chk("e_ignored_count", 64'(hs_log.size()), 64'd3);
    chk("e_ignored_last", (hs_log.size() > 2) ? hs_log[2] : '1, 64'h2_1000);

    // F: reset in the middle of issuing
    rq.AXIS_RQ_TREADY = 1'b1;
    start_job(64'h4000_0000, 32'd30);
    k = 0;
    while (!(m_out == 7 && rq.AXIS_RQ_TVALID) && k < 50) begin step(); k++; end
    chk("f_reach7", 64'(outstanding), 64'd7);
    reset = 1'b1; step(); reset = 1'b0;
    chk_reset_values("f_rst");
    hs_log.delete(); done_pulses = 0;
    start_job(64'h0, 32'd2);
    finish_job(100);
    chk("f_count", 64'(hs_log.size()), 64'd2);
    chk("f_addr0", (hs_log.size() > 0) ? hs_log[0] : '1, 64'h0);
    chk("f_addr1", (hs_log.size() > 1) ? hs_log[1] : '1, 64'h800);
    chk("f_done", 64'(done_pulses), 64'd1);

    // Random jobs against the reference, some near address wrap
    for (int j = 0; j < 12; j++) begin
      b = {$urandom, $urandom};
      if (j % 4 == 0) b = 64'hFFFF_FFFF_FFFF_E800;
      n = 32'($urandom_range(0, 40));
      hs_log.delete(); done_pulses = 0;
      row_complete = 1'b0;
      start_job(b, n);
      k = 0;
      while (m_busy && k < 3000) begin
        rq.AXIS_RQ_TREADY = ($urandom_range(0, 3) != 0);
        row_complete = (m_out > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 29) == 0);
        abort = ($urandom_range(0, 199) == 0);
        step();
        k++;
      end
      abort = 1'b0; row_complete = 1'b0;
      chk("rnd_done", 64'(m_busy), 64'd0);
      chk("rnd_pulses", 64'(done_pulses), 64'd1);
      if (!m_abort) chk("rnd_count", 64'(hs_log.size()), 64'(n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/row_request_scheduler.md
Name: row_request_scheduler

Overview:
- Sequences a data-set transfer: issues one AXI-Stream read request per 2048-byte row and throttles on a credit window of outstanding rows.
- Returns credits on the row_complete pulses from the two-channel stream consumer.
- Drives row_requestor_idle to that consumer, so the consumer can tell an underflow from job completion.
- Sits between the host-side control registers and the PCIe/QSFP request path.

Parameters:
- ADDR_WIDTH, 64, width of row byte address on request bus
- ROW_BYTES, 2048, address stride between consecutive rows (power of two)
- MAX_OUTSTANDING, 16, credit window (max requested-but-incomplete rows), 1..255

Ports:
- clk  in  1  single clock for all logic
- reset  in  1  synchronous, active-high; clears all state
- start  in  1  pulse; begin job using base_addr/total_rows sampled this cycle
- abort  in  1  pulse; stop issuing new requests
- base_addr  in  ADDR_WIDTH  byte address of row 0
- total_rows  in  32  rows in the job
- row_complete  in  1  one-cycle pulse per row fully received
- AXIS_RQ_TDATA  out  ADDR_WIDTH  byte address of requested row
- AXIS_RQ_TVALID  out  1  request valid
- AXIS_RQ_TREADY  in  1  downstream accepts request
- row_requestor_idle  out  1  high when no further requests will be issued
- outstanding  out  8  rows requested but not yet completed
- rows_requested  out  32  requests handshaken this job
- spurious_completions  out  16  row_complete pulses seen with outstanding==0, saturating
- job_done  out  1  one-cycle pulse when the job finishes

Behaviour:
- Reset values:
  - state=IDLE, TVALID=0, TDATA=0.
  - row_requestor_idle=1.
  - outstanding=0, rows_requested=0, spurious_completions=0, job_done=0.
- States:
  - IDLE: row_requestor_idle=1. On start:
    - latch base_addr and total_rows;
    - clear rows_requested, outstanding and spurious_completions;
    - go to ISSUE, or to DRAIN if total_rows==0.
  - ISSUE: row_requestor_idle=0.
    - TVALID=1 when outstanding < MAX_OUTSTANDING, else TVALID=0 (credit stall).
    - TDATA = latched_base + rows_requested*ROW_BYTES, modulo 2^ADDR_WIDTH.
    - On handshake: rows_requested+1.
    - If that was the last row, or abort has been seen, go to DRAIN.
  - DRAIN: row_requestor_idle=1, TVALID=0.
    - When outstanding==0, pulse job_done for one cycle and go to IDLE.
- AXIS rules:
  - Once TVALID rises, TVALID and TDATA stay stable until TREADY.
  - TVALID is raised no earlier than 1 cycle after entering ISSUE.
  - TVALID is never dropped without a handshake.
  - abort asserted while TVALID=1 is remembered; the pending request completes, then the block goes to DRAIN.
  - abort with TVALID=0 in ISSUE goes to DRAIN next cycle.
- Credits:
  - outstanding+1 on handshake, -1 on row_complete.
  - Both in the same cycle leave it unchanged.
  - row_complete with outstanding==0 leaves outstanding at 0 and increments spurious_completions, saturating at 16'hFFFF.
  - The credit check uses the registered outstanding value, so the window is never exceeded.
- start while not IDLE is ignored. abort in IDLE or DRAIN is ignored.
- job_done with total_rows==0: IDLE → DRAIN → job_done pulse → IDLE, i.e. job_done exactly 2 cycles after start.
- The row_requestor_idle falling edge marks a new data set for the consumer. It is low for at least 1 cycle for any job with total_rows>0.
- Reset mid-operation returns to reset values next cycle. An in-flight TVALID is dropped; this is permitted only on reset.
- The address increment uses a running adder (addr += ROW_BYTES), not a multiplier.

Decomposition:
- Shared package: state encoding (IDLE/ISSUE/DRAIN) and ROW_BYTES default 2048.
- The consumer's DATA_CYCLES_PER_ROW derives from the same ROW_BYTES constant.
- One natural sub-module: credit_counter (inc/dec/saturating spurious count, exposes outstanding and has_credit).
- The FSM and address generator stay in the top module.

Test Plan:
- total_rows=4, base=0x1000, TREADY=1, immediate row_complete per request → TDATA 0x1000, 0x1800, 0x2000, 0x2800; row_requestor_idle low from cycle after start until 4th handshake; job_done after 4th completion.
- total_rows=40, MAX_OUTSTANDING=16, no row_complete → exactly 16 handshakes, TVALID=0 with outstanding=16. Then one row_complete → exactly one more request.
- TREADY held low 10 cycles with abort pulsed at cycle 3 → TDATA stable throughout; after TREADY, rows_requested=1 and state DRAIN; job_done once outstanding reaches 0.
- Same-cycle handshake and row_complete at outstanding=5 → outstanding stays 5. row_complete at outstanding=0 → spurious_completions=1, outstanding=0.
- total_rows=0 → no TVALID, row_requestor_idle stays 1, job_done 2 cycles after start. start during ISSUE → ignored, latched total unchanged.
- reset asserted mid-ISSUE with 7 outstanding → next cycle all outputs at reset values. A following start runs normally from row 0.
